button_conditioner: RTL and testbench

//  Input-side front end for the clock/time-set panel: debounces the two raw push-buttons (ADD, STATE).
//  - Outputs clean levels and single-cycle press pulses, plus a 2-bit edit-mode register (0..3).
//  - Sits between the board KEY pins and the time-keeping core.
//  - Generates the button_add / button_state strobes and the edit state the core consumes.
//  - Runs entirely in the clk50 domain.

---
 rtl/button_conditioner_if.sv | 21 ++
 rtl/button_conditioner.sv | 125 ++++++++++++
 tb/tb_button_conditioner.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
// Button conditioner bus: raw key inputs and mode clear in, conditioned levels, strobes and edit mode out.
interface button_conditioner_if;
  logic       key_add_n;
  logic       key_state_n;
  logic       mode_clr;
  logic       add_level;
  logic       state_level;
  logic       add_pulse;
  logic       state_pulse;
  logic [1:0] mode;

  modport master (
    output key_add_n, key_state_n, mode_clr,
    input  add_level, state_level, add_pulse, state_pulse, mode
  );

  modport slave (
    input  key_add_n, key_state_n, mode_clr,
    output add_level, state_level, add_pulse, state_pulse, mode
  );
endinterface

// File: rtl/button_conditioner.sv
// Debounces the ADD/STATE keys into levels, press strobes and a 2-bit edit mode.
// Define AUTO_REPEAT_EN to add hold-to-repeat strobes on ADD.
module button_conditioner #(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned DEBOUNCE_MS     = 20,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100
) (
  input  logic                 clk50,
  input  logic                 reset_n,
  button_conditioner_if.slave  bus
);

  localparam int unsigned CYC_PER_MS = CLK_HZ / 1000;
  localparam int unsigned DB_CYC     = CYC_PER_MS * DEBOUNCE_MS;
  localparam int unsigned RD_CYC     = CYC_PER_MS * REPEAT_DELAY_MS;
  localparam int unsigned RR_CYC     = CYC_PER_MS * REPEAT_RATE_MS;
  localparam int unsigned DB_W       = $clog2(DB_CYC + 1);

  if (DB_CYC < 2 || RD_CYC < 2 || RR_CYC < 2) begin : g_cfg_check
    $error("button_conditioner: derived cycle counts must be at least 2");
  end

  // Bit 0 = ADD, bit 1 = STATE
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            level_q, level_d;
  logic [1:0]            prev_q;
  logic [1:0]            pulse_q, pulse_d;
  logic [1:0][DB_W-1:0]  cnt_q, cnt_d;
  logic [1:0]            mode_q, mode_d;

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      prev_q  <= '0;
      pulse_q <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
    end else begin
      sync1_q <= ~{bus.key_state_n, bus.key_add_n};
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // Level toggles only after DB_CYC consecutive mismatching cycles
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == DB_W'(DB_CYC - 1)) begin
          level_d[i] = ~level_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RP_MAX = (RD_CYC > RR_CYC) ? RD_CYC : RR_CYC;
  localparam int unsigned RP_W   = $clog2(RP_MAX + 1);

  logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic            rep_rate_q, rep_rate_d;
  logic            rep_fire;

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      rep_cnt_q  <= '0;
      rep_rate_q <= 1'b0;
    end else begin
      rep_cnt_q  <= rep_cnt_d;
      rep_rate_q <= rep_rate_d;
    end
  end

  // Runs from the cycle after the press strobe; first period RD_CYC, then RR_CYC
  always_comb begin
    rep_cnt_d  = '0;
    rep_rate_d = 1'b0;
    rep_fire   = 1'b0;
    if (level_q[0] && prev_q[0]) begin
      rep_rate_d = rep_rate_q;
      if (rep_cnt_q == (rep_rate_q ? RP_W'(RR_CYC - 1) : RP_W'(RD_CYC - 1))) begin
        rep_fire   = 1'b1;
        rep_rate_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + RP_W'(1);
      end
    end
  end
`endif

  always_comb begin
    pulse_d = level_q & ~prev_q;
`ifdef AUTO_REPEAT_EN
    pulse_d[0] = pulse_d[0] | rep_fire;
`endif
  end

  // Clear wins over a simultaneous STATE strobe
  always_comb begin
    mode_d = mode_q;
    if (bus.mode_clr) begin
      mode_d = '0;
    end else if (pulse_q[1]) begin
      mode_d = mode_q + 2'd1;
    end
  end

  assign bus.add_level   = level_q[0];
  assign bus.state_level = level_q[1];
  assign bus.add_pulse   = pulse_q[0];
  assign bus.state_pulse = pulse_q[1];
  assign bus.mode        = mode_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner at DB=4, RD=10, RR=3 cycles.
module tb_button_conditioner;

  logic clk50 = 1'b0;
  logic reset_n;

  button_conditioner_if bus ();

  button_conditioner #(
    .CLK_HZ          (1000),
    .DEBOUNCE_MS     (4),
    .REPEAT_DELAY_MS (10),
    .REPEAT_RATE_MS  (3)
  ) dut (
    .clk50   (clk50),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk50 = ~clk50;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int          add_cnt;
  int          state_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      tick();
      add_cnt   += int'(bus.add_pulse);
      state_cnt += int'(bus.state_pulse);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_flags"}, 32'({bus.add_level, bus.state_level, bus.add_pulse, bus.state_pulse}), 0);
    check_eq({tag, "_mode"}, 32'(bus.mode), 0);
  endtask

  initial begin
    reset_n         = 1'b0;
    bus.key_add_n   = 1'b1;
    bus.key_state_n = 1'b1;
    bus.mode_clr    = 1'b0;
    add_cnt         = 0;
    state_cnt       = 0;
    repeat (3) @(posedge clk50);
    #1;
    check_idle("reset");
    reset_n = 1'b1;
    run(4);

    // Clean ADD press: level at +6, single strobe at +7
    bus.key_add_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check_eq($sformatf("t1_level_c%0d", k), 32'(bus.add_level), 32'(k >= 6));
      check_eq($sformatf("t1_pulse_c%0d", k), 32'(bus.add_pulse), 32'(k == 7));
    end
    bus.key_add_n = 1'b1;
    add_cnt = 0;
    run(12);
    check_eq("t1_release_pulses", 32'(add_cnt), 0);
    check_eq("t1_release_level", 32'(bus.add_level), 0);

    // 3-cycle bounce is rejected
    add_cnt = 0;
    bus.key_add_n = 1'b0;
    run(3);
    bus.key_add_n = 1'b1;
    run(12);
    check_eq("t2_bounce_pulses", 32'(add_cnt), 0);
    check_eq("t2_bounce_level", 32'(bus.add_level), 0);

    // Chatter then steady low gives exactly one strobe
    add_cnt = 0;
    bus.key_add_n = 1'b0; run(1);
    bus.key_add_n = 1'b1; run(1);
    bus.key_add_n = 1'b0; run(2);
    bus.key_add_n = 1'b1; run(1);
    bus.key_add_n = 1'b0; run(8);
    check_eq("t2_chatter_pulses", 32'(add_cnt), 1);
    check_eq("t2_chatter_level", 32'(bus.add_level), 1);
    bus.key_add_n = 1'b1;
    add_cnt = 0;
    run(12);
    check_eq("t2_chatter_release_pulses", 32'(add_cnt), 0);
    check_eq("t2_chatter_release_level", 32'(bus.add_level), 0);

    // Mode stepping with wrap
    check_eq("t3_mode_start", 32'(bus.mode), 0);
    for (int i = 0; i < 5; i++) begin
      state_cnt = 0;
      bus.key_state_n = 1'b0;
      run(8);
      bus.key_state_n = 1'b1;
      run(8);
      check_eq($sformatf("t3_state_pulses_%0d", i), 32'(state_cnt), 1);
      check_eq($sformatf("t3_mode_%0d", i), 32'(bus.mode), 32'((i + 1) % 4));
    end

    // mode_clr coincident with the STATE strobe
    bus.key_state_n = 1'b0;
    run(7);
    check_eq("t3_clr_pulse", 32'(bus.state_pulse), 1);
    bus.mode_clr = 1'b1;
    tick();
    bus.mode_clr = 1'b0;
    check_eq("t3_clr_mode", 32'(bus.mode), 0);
    bus.key_state_n = 1'b1;
    run(8);
    check_eq("t3_clr_mode_hold", 32'(bus.mode), 0);

    // One more press so reset has a nonzero mode to clear
    bus.key_state_n = 1'b0;
    run(8);
    bus.key_state_n = 1'b1;
    run(8);
    check_eq("t4_mode_before", 32'(bus.mode), 1);

    // Reset mid-debounce with ADD held
    bus.key_add_n = 1'b0;
    run(4);
    reset_n = 1'b0;
    #1;
    check_idle("t4_in_reset");
    tick();
    tick();
    check_idle("t4_in_reset_late");
    reset_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check_eq($sformatf("t4_pulse_c%0d", k), 32'(bus.add_pulse), 32'(k == 7));
    end
    bus.key_add_n = 1'b1;
    run(12);

    // Long hold: repeat strobes only when the feature is built in
    bus.key_add_n = 1'b0;
    run(7);
    check_eq("t5_press_pulse", 32'(bus.add_pulse), 1);
    for (int k = 1; k <= 40; k++) begin
      logic exp_p;
      tick();
`ifdef AUTO_REPEAT_EN
      exp_p = (k >= 10) && (k <= 28) && (((k - 10) % 3) == 0);
`else
      exp_p = 1'b0;
`endif
      check_eq($sformatf("t5_pulse_p%0d", k), 32'(bus.add_pulse), 32'(exp_p));
      if (k == 24) bus.key_add_n = 1'b1;
    end
    check_eq("t5_level_released", 32'(bus.add_level), 0);

    // Simultaneous presses
    check_eq("t6_mode_before", 32'(bus.mode), 0);
    bus.key_add_n   = 1'b0;
    bus.key_state_n = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_eq($sformatf("t6_add_pulse_c%0d", k), 32'(bus.add_pulse), 32'(k == 7));
      check_eq($sformatf("t6_state_pulse_c%0d", k), 32'(bus.state_pulse), 32'(k == 7));
    end
    check_eq("t6_mode_after", 32'(bus.mode), 1);
    bus.key_add_n   = 1'b1;
    bus.key_state_n = 1'b1;
    run(12);
    check_eq("t6_levels_released", 32'({bus.add_level, bus.state_level}), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
